div_ratio_scheduler: RTL and testbench

Controller that owns the divide ratio `N` of the 4-bit frequency divider. It arbitrates ratio-change requests from two requesters with round-robin priority and holds each accepted ratio until the divider's current output period completes. It then applies the ratio on the wrap boundary, so the divided output never shows a truncated or stretched period. It sits beside the divider on the same clock and drives the divider's `N` input directly.

---
 rtl/freq_div_pkg.sv | 20 ++
 rtl/div_phase_tracker.sv | 35 +++
 rtl/div_ratio_scheduler.sv | 121 ++++++++++++
 tb/tb_div_ratio_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// rtl/freq_div_pkg.sv - shared types and constants for the divide-ratio scheduler
package freq_div_pkg;

    localparam int NW = 4;
    localparam logic [NW-1:0] N_ONE = 4'd1;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    // Index of a requester; also used as the round-robin "favoured" pointer.
    typedef logic req_idx_t;

    // Last cycle of an output period; ratios 0 and 1 wrap every cycle.
    function automatic logic calc_wrap(input logic [NW-1:0] n, input logic [NW-1:0] ph);
        return (n <= N_ONE) || (ph == (n - N_ONE));
    endfunction

endpackage

// File: rtl/div_phase_tracker.sv
// rtl/div_phase_tracker.sv - shadow of the divider counter and period-wrap flag
module div_phase_tracker
    import freq_div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [NW-1:0] n_active,
    input  logic          load_zero,
    output logic [NW-1:0] phase,
    output logic          wrap
);

    logic [NW-1:0] phase_q;
    logic [NW-1:0] phase_d;

    assign wrap  = calc_wrap(n_active, phase_q);
    assign phase = phase_q;

    // The wrap term also pins phase at 0 for ratios 0 and 1.
    always_comb begin
        phase_d = phase_q + N_ONE;
        if (load_zero || wrap) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/div_ratio_scheduler.sv
// rtl/div_ratio_scheduler.sv - arbitrates ratio requests and applies them on period wraps
module div_ratio_scheduler
    import freq_div_pkg::*;
#(
    parameter logic [3:0]  RESET_N   = 4'd2,
    parameter int unsigned MIN_DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_n0,
    input  logic [3:0] req_n1,
    output logic [1:0] req_ready,
    output logic [3:0] n_active,
    output logic       n_update,
    output logic [3:0] phase,
    output logic       wrap,
    output logic       busy
);

    localparam logic [NW-1:0] DWELL_MAX = MIN_DWELL[NW-1:0];

    state_e        state_q, state_d;
    req_idx_t      rr_q, rr_d;
    logic [NW-1:0] n_pend_q, n_pend_d;
    logic [NW-1:0] n_active_q, n_active_d;
    logic          n_update_q, n_update_d;
    logic [NW-1:0] dwell_q, dwell_d;

    logic          dwell_ok;
    logic          apply;
    logic          grant0, grant1;
    logic [1:0]    xfer;
    logic [NW-1:0] offered;

    div_phase_tracker u_phase (
        .clk       (clk),
        .rst       (rst),
        .n_active  (n_active_q),
        .load_zero (apply),
        .phase     (phase),
        .wrap      (wrap)
    );

    assign dwell_ok = (dwell_q == DWELL_MAX);
    assign apply    = (state_q == PENDING) && wrap;

    // A lone valid requester wins outright; contention is settled by the pointer.
    assign grant0 = !req_valid[1] || (req_valid[0] && (rr_q == 1'b0));
    assign grant1 = !req_valid[0] || (req_valid[1] && (rr_q == 1'b1));

    always_comb begin
        req_ready = 2'b00;
        if ((state_q == IDLE) && dwell_ok) begin
            req_ready = {grant1, grant0};
        end
    end

    assign xfer    = req_valid & req_ready;
    assign offered = xfer[1] ? req_n1 : req_n0;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        n_pend_d   = n_pend_q;
        n_active_d = n_active_q;
        n_update_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|xfer) begin
                    rr_d = xfer[0];
                    // Re-requesting the running ratio is consumed without disturbing the divider.
                    if (offered != n_active_q) begin
                        n_pend_d = offered;
                        state_d  = PENDING;
                    end
                end
            end
            PENDING: begin
                if (wrap) begin
                    n_active_d = n_pend_q;
                    n_update_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dwell_d = dwell_q;
        if (apply) begin
            dwell_d = '0;
        end else if (wrap && !dwell_ok) begin
            dwell_d = dwell_q + N_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            n_pend_q   <= '0;
            n_active_q <= RESET_N;
            n_update_q <= 1'b0;
            dwell_q    <= DWELL_MAX;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            n_pend_q   <= n_pend_d;
            n_active_q <= n_active_d;
            n_update_q <= n_update_d;
            dwell_q    <= dwell_d;
        end
    end

    assign n_active = n_active_q;
    assign n_update = n_update_q;
    assign busy     = (state_q == PENDING);

endmodule

// File: tb/tb_div_ratio_scheduler.sv
// tb/tb_div_ratio_scheduler.sv - directed and randomized checks of div_ratio_scheduler
module tb_div_ratio_scheduler;

    localparam int MIN_DW = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [3:0] req_n0 = 4'd0;
    logic [3:0] req_n1 = 4'd0;
    logic [1:0] req_ready;
    logic [3:0] n_active;
    logic       n_update;
    logic [3:0] phase;
    logic       wrap;
    logic       busy;

    int total = 0;
    int bad   = 0;

    div_ratio_scheduler #(.RESET_N(4'd2), .MIN_DWELL(MIN_DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_n0    (req_n0),
        .req_n1    (req_n1),
        .req_ready (req_ready),
        .n_active  (n_active),
        .n_update  (n_update),
        .phase     (phase),
        .wrap      (wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench mid-cycle in the first cycle after reset release.
    task automatic apply_reset();
        rst       = 1'b0;
        req_valid = 2'b00;
        req_n0    = 4'd0;
        req_n1    = 4'd0;
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 2'b00;
        @(posedge clk);
        #3;
        total++; if (n_active !== 4'd2) begin bad++; $display("FAIL rst_n_active got=%0d exp=2", n_active); end
        total++; if (phase !== 4'd0) begin bad++; $display("FAIL rst_phase got=%0d exp=0", phase); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (n_update !== 1'b0) begin bad++; $display("FAIL rst_n_update got=%0b exp=0", n_update); end
        rst = 1'b1;
        #2;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin nxt(); #2; end
            total++; if (phase !== 4'(k % 2)) begin bad++; $display("FAIL rel_phase[%0d] got=%0d exp=%0d", k, phase, k % 2); end
            total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL rel_ready[%0d] got=%b exp=11", k, req_ready); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rel_busy[%0d] got=%0b exp=0", k, busy); end
        end
    endtask

    task automatic test_apply_basic();
        apply_reset();
        req_valid = 2'b01;
        req_n0    = 4'd5;
        #2;
        total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=x1", req_ready); end
        nxt();
        req_valid = 2'b00;
        #2;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        total++; if (wrap !== 1'b1) begin bad++; $display("FAIL basic_wrap got=%0b exp=1", wrap); end
        total++; if (n_update !== 1'b0) begin bad++; $display("FAIL basic_early_upd got=%0b exp=0", n_update); end
        nxt(); #2;
        total++; if (n_update !== 1'b1) begin bad++; $display("FAIL basic_upd got=%0b exp=1", n_update); end
        total++; if (n_active !== 4'd5) begin bad++; $display("FAIL basic_n_active got=%0d exp=5", n_active); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_clr got=%0b exp=0", busy); end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin nxt(); #2; end
            total++; if (phase !== 4'(k % 5)) begin bad++; $display("FAIL basic_phase[%0d] got=%0d exp=%0d", k, phase, k % 5); end
        end
    endtask

    task automatic test_rr_dwell();
        int  c;
        bit  found;
        apply_reset();
        req_valid = 2'b11;
        req_n0    = 4'd3;
        req_n1    = 4'd7;
        #2;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rr_first got=%b exp=01", req_ready); end
        nxt(); #2;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rr_pend_ready got=%b exp=00", req_ready); end
        nxt(); #2;
        total++; if (n_update !== 1'b1 || n_active !== 4'd3) begin bad++; $display("FAIL rr_apply3 got=%0b/%0d exp=1/3", n_update, n_active); end
        c = 0; found = 0;
        for (int k = 1; k <= 12 && !found; k++) begin
            nxt(); #2;
            if (req_ready[1] === 1'b1) begin found = 1; c = k; end
        end
        total++; if (c != 6) begin bad++; $display("FAIL rr_dwell_cycles got=%0d exp=6", c); end
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rr_second got=%b exp=10", req_ready); end
        c = 0; found = 0;
        for (int k = 1; k <= 8 && !found; k++) begin
            nxt();
            if (k == 1) req_valid = 2'b00;
            #2;
            if (n_update === 1'b1) begin found = 1; c = k; end
        end
        total++; if (c != 3) begin bad++; $display("FAIL rr_latency7 got=%0d exp=3", c); end
        total++; if (n_active !== 4'd7) begin bad++; $display("FAIL rr_n_active7 got=%0d exp=7", n_active); end
    endtask

    task automatic test_zero_ratio();
        apply_reset();
        req_valid = 2'b01;
        req_n0    = 4'd0;
        nxt(); req_valid = 2'b00;
        nxt(); #2;
        total++; if (n_active !== 4'd0 || n_update !== 1'b1) begin bad++; $display("FAIL zero_apply got=%0d/%0b exp=0/1", n_active, n_update); end
        for (int k = 0; k < 2; k++) begin
            if (k > 0) begin nxt(); #2; end
            total++; if (wrap !== 1'b1 || phase !== 4'd0) begin bad++; $display("FAIL zero_wrap[%0d] got=%0b/%0d exp=1/0", k, wrap, phase); end
            total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL zero_dwell[%0d] got=%b exp=00", k, req_ready); end
        end
        nxt();
        req_valid = 2'b01;
        req_n0    = 4'd3;
        #2;
        total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=x1", req_ready); end
        nxt(); req_valid = 2'b00; #2;
        total++; if (n_update !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL zero_pend got=%0b/%0b exp=0/1", n_update, busy); end
        nxt(); #2;
        total++; if (n_update !== 1'b1 || n_active !== 4'd3) begin bad++; $display("FAIL zero_to3 got=%0b/%0d exp=1/3", n_update, n_active); end
    endtask

    task automatic test_same_ratio();
        apply_reset();
        req_valid = 2'b01;
        req_n0    = 4'd2;
        #2;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL same_ready got=%b exp=01", req_ready); end
        nxt();
        req_valid = 2'b11;
        req_n0    = 4'd4;
        req_n1    = 4'd6;
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL same_busy got=%0b exp=0", busy); end
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL same_ptr got=%b exp=10", req_ready); end
        for (int k = 0; k < 3; k++) begin
            total++; if (n_update !== 1'b0 || n_active !== 4'd2) begin bad++; $display("FAIL same_noupd[%0d] got=%0b/%0d exp=0/2", k, n_update, n_active); end
            nxt(); req_valid = 2'b00; #2;
        end
    endtask

    task automatic test_reset_pending();
        apply_reset();
        req_valid = 2'b01;
        req_n0    = 4'd9;
        nxt(); req_valid = 2'b00; #2;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rp_busy got=%0b exp=1", busy); end
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || n_active !== 4'd2 || phase !== 4'd0 || n_update !== 1'b0) begin
            bad++; $display("FAIL rp_async got=%0b/%0d/%0d/%0b exp=0/2/0/0", busy, n_active, phase, n_update);
        end
        nxt(); nxt(); #2;
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            nxt(); #2;
            total++; if (n_update !== 1'b0 || n_active !== 4'd2) begin bad++; $display("FAIL rp_after[%0d] got=%0b/%0d exp=0/2", k, n_update, n_active); end
        end
    endtask

    task automatic test_random();
        int  m_n, m_phase, m_pn, m_dwell;
        bit  m_pend, m_ptr, m_upd, m_wrap, ok, s0, s1;
        logic [1:0] exp_ready, x;
        int  offer;
        apply_reset();
        m_n = 2; m_phase = 0; m_pn = 0; m_dwell = MIN_DW;
        m_pend = 0; m_ptr = 0; m_upd = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i > 0) nxt();
            req_valid = 2'($urandom_range(0, 3));
            req_n0 = ($urandom_range(0, 3) == 0) ? 4'(m_n) : 4'($urandom_range(0, 6));
            req_n1 = ($urandom_range(0, 3) == 0) ? 4'(m_n) : 4'($urandom_range(0, 6));
            #2;
            m_wrap = (m_n <= 1) || (m_phase == m_n - 1);
            ok = !m_pend && (m_dwell >= MIN_DW);
            s0 = !req_valid[1] || (req_valid[0] && !m_ptr);
            s1 = !req_valid[0] || (req_valid[1] && m_ptr);
            exp_ready = ok ? {s1, s0} : 2'b00;
            total++; if (n_active !== 4'(m_n)) begin bad++; $display("FAIL rnd_n_active[%0d] got=%0d exp=%0d", i, n_active, m_n); end
            total++; if (phase !== 4'(m_phase)) begin bad++; $display("FAIL rnd_phase[%0d] got=%0d exp=%0d", i, phase, m_phase); end
            total++; if (wrap !== m_wrap) begin bad++; $display("FAIL rnd_wrap[%0d] got=%0b exp=%0b", i, wrap, m_wrap); end
            total++; if (busy !== m_pend) begin bad++; $display("FAIL rnd_busy[%0d] got=%0b exp=%0b", i, busy, m_pend); end
            total++; if (n_update !== m_upd) begin bad++; $display("FAIL rnd_n_update[%0d] got=%0b exp=%0b", i, n_update, m_upd); end
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, req_ready, exp_ready); end
            x = req_valid & exp_ready;
            m_upd = 0;
            if (m_pend && m_wrap) begin
                m_n = m_pn; m_phase = 0; m_dwell = 0; m_pend = 0; m_upd = 1;
            end else begin
                m_phase = (m_n <= 1) ? 0 : (m_phase + 1) % m_n;
                if (m_wrap && m_dwell < MIN_DW) m_dwell++;
                if (x != 2'b00) begin
                    offer = x[1] ? int'(req_n1) : int'(req_n0);
                    m_ptr = !x[1];
                    if (offer != m_n) begin m_pend = 1; m_pn = offer; end
                end
            end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_apply_basic();
        test_rr_dwell();
        test_zero_ratio();
        test_same_ratio();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
